if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSN, 32'h0000_0013, instruction placed in id_insn for bubbles.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  ID stage hold request.
REQ-006 br_tkn  input  1  redirect request, one-cycle pulse.
REQ-007 br_addr  input  32  redirect target.
REQ-008 insn  input  32  instruction word from the L1 instruction cache.
REQ-009 if_busy  input  1  cache miss stall from the L1 instruction cache.
REQ-010 data_rdy  input  1  cache tag-hit / data-valid from the L1 instruction cache.
REQ-011 if_pc  output  32  current fetch address to the L1 instruction cache.
REQ-012 id_pc  output  32  PC of the instruction in the IF/ID register.
REQ-013 id_insn  output  32  instruction in the IF/ID register.
REQ-014 id_en  output  1  IF/ID register holds a valid instruction.
REQ-015 miss_cnt  output  32  miss-stall cycle count (present only with IF_PERF_CNT_EN).

Function
REQ-016 States SHALL be FETCH, MISS and REDIR_PEND, encoded in 2 bits.
REQ-017 Update priority SHALL be rst > br_tkn > stall > if_busy > normal fetch.
REQ-018 FETCH, data_rdy=1, if_busy=0, stall=0: id_insn<=insn, id_pc<=if_pc, id_en<=1, if_pc<=if_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0).
REQ-019 FETCH, if_busy=1: go to MISS, hold if_pc, id_insn<=NOP_INSN, id_en<=0 unless stall=1 (then IF/ID holds).
REQ-020 MISS: hold if_pc; return to FETCH in the cycle if_busy=0 and data_rdy=1, then perform REQ-018 in that same cycle.
REQ-021 stall=1 with br_tkn=0: if_pc, id_pc, id_insn, id_en and state all hold.
REQ-022 br_tkn=1 in FETCH: if_pc<={br_addr[31:2],2'b00}, id_en<=0, id_insn<=NOP_INSN, state stays FETCH; stall in that cycle is ignored.
REQ-023 br_tkn=1 in MISS: latch {br_addr[31:2],2'b00} into a pending register, go to REDIR_PEND, hold if_pc until the refill ends.
REQ-024 REDIR_PEND: if_pc holds while if_busy=1; on the first cycle if_busy=0, discard insn, set if_pc<=pending target, id_en<=0, go to FETCH.
REQ-025 A second br_tkn in REDIR_PEND SHALL overwrite the pending target.
REQ-026 if_pc SHALL be driven from a register, with no combinational path from any input.
REQ-027 id_en SHALL never be 1 for an instruction captured while data_rdy=0.

Reset
REQ-028 rst=1 at a clock edge SHALL set:
- if_pc<=RESET_VECTOR, id_pc<=0, id_insn<=NOP_INSN, id_en<=0;
- state<=FETCH, pending target<=0, miss_cnt<=0.
REQ-029 A reset asserted mid-miss SHALL abandon the miss and the pending redirect; the first post-reset fetch is RESET_VECTOR.

Configuration
REQ-030 With macro IF_PERF_CNT_EN defined:
- miss_cnt increments by 1 every cycle state is MISS or REDIR_PEND with rst=0;
- it saturates at 32'hFFFF_FFFF.
REQ-031 Without IF_PERF_CNT_EN, miss_cnt and its counter logic SHALL be absent.

Structure
REQ-032 Shared package holds the state encodings (IF_FETCH=2'd0, IF_MISS=2'd1, IF_REDIR_PEND=2'd2), the 32-bit word width and NOP_INSN.
REQ-033 The block is a single module; no sub-module.

Verification
REQ-034 Reset release, data_rdy=1 steady, insn=i0,i1,i2 -> if_pc 0,4,8,12; id_pc 0,4,8 with id_en=1 one cycle after each fetch.
REQ-035 if_busy=1 for 5 cycles at if_pc=0x40 -> if_pc holds 0x40, id_en=0 throughout; fetch resumes at 0x40; miss_cnt=5 with IF_PERF_CNT_EN.
REQ-036 stall=1 for 3 cycles with id_pc=0x10 -> all outputs unchanged; the next cycle id_pc=0x14.
REQ-037 br_tkn=1, br_addr=0x203 in FETCH -> next if_pc=0x200, id_en=0, id_insn=NOP_INSN.
REQ-038 br_tkn=1, br_addr=0x300 during a miss at 0x80, if_busy drops 3 cycles later -> insn at 0x80 never reaches ID (id_en=0); if_pc=0x300 the cycle after if_busy falls.
REQ-039 if_pc=0xFFFF_FFFC with a fetch hit -> next if_pc=0; rst=1 mid-miss -> if_pc=RESET_VECTOR, state FETCH, miss_cnt=0.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: word width,
// bubble instruction, FSM state encoding and a PC alignment helper.
package if_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] IF_NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_FETCH      = 2'd0,
    IF_MISS       = 2'd1,
    IF_REDIR_PEND = 2'd2
  } if_state_e;

  // Force a byte address onto a 4-byte instruction boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN - 2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives the fetch PC to the L1 I-cache, fills
// the IF/ID register, rides out cache misses and defers redirects that arrive
// during a refill until the refill ends.
// Optional feature: define IF_PERF_CNT_EN to add the saturating miss_cnt output.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSN     = IF_NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_tkn,
  input  logic [XLEN-1:0] br_addr,
  input  logic [XLEN-1:0] insn,
  input  logic            if_busy,
  input  logic            data_rdy,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_insn,
  output logic            id_en
`ifdef IF_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] miss_cnt
`endif
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_insn_q, id_insn_d;
  logic            id_en_q, id_en_d;
  logic [XLEN-1:0] pend_q, pend_d;

  // Next-state logic; priority is br_tkn > stall > if_busy > normal fetch.
  always_comb begin
    state_d   = state_q;
    if_pc_d   = if_pc_q;
    id_pc_d   = id_pc_q;
    id_insn_d = id_insn_q;
    id_en_d   = id_en_q;
    pend_d    = pend_q;

    if (br_tkn) begin
      // Redirect flushes IF/ID and overrides any stall this cycle.
      id_en_d   = 1'b0;
      id_insn_d = NOP_INSN;
      if (state_q == IF_FETCH) begin
        if_pc_d = word_align(br_addr);
      end else begin
        // A refill is in flight: park the target until the cache is free.
        pend_d  = word_align(br_addr);
        state_d = IF_REDIR_PEND;
      end
    end else if (!stall) begin
      if (if_busy) begin
        id_en_d   = 1'b0;
        id_insn_d = NOP_INSN;
        if (state_q == IF_FETCH) begin
          state_d = IF_MISS;
        end
      end else if (state_q == IF_REDIR_PEND) begin
        // Refill done; its data belongs to the abandoned path, so drop it.
        if_pc_d   = pend_q;
        id_en_d   = 1'b0;
        id_insn_d = NOP_INSN;
        state_d   = IF_FETCH;
      end else if (data_rdy) begin
        id_pc_d   = if_pc_q;
        id_insn_d = insn;
        id_en_d   = 1'b1;
        if_pc_d   = if_pc_q + XLEN'(4);
        state_d   = IF_FETCH;
      end else begin
        // No valid data: never mark IF/ID valid.
        id_en_d   = 1'b0;
        id_insn_d = NOP_INSN;
      end
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IF_FETCH;
      if_pc_q   <= RESET_VECTOR;
      id_pc_q   <= '0;
      id_insn_q <= NOP_INSN;
      id_en_q   <= 1'b0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      if_pc_q   <= if_pc_d;
      id_pc_q   <= id_pc_d;
      id_insn_q <= id_insn_d;
      id_en_q   <= id_en_d;
      pend_q    <= pend_d;
    end
  end

  assign if_pc   = if_pc_q;
  assign id_pc   = id_pc_q;
  assign id_insn = id_insn_q;
  assign id_en   = id_en_q;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] miss_cnt_q;

  // Saturating count of cycles spent waiting on a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_q <= '0;
    end else if ((state_q == IF_MISS || state_q == IF_REDIR_PEND) && (miss_cnt_q != '1)) begin
      miss_cnt_q <= miss_cnt_q + XLEN'(1);
    end
  end

  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the fetch rules.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, br_tkn, if_busy, data_rdy;
  logic [31:0] br_addr, insn;
  logic [31:0] if_pc, id_pc, id_insn;
  logic        id_en;
`ifdef IF_PERF_CNT_EN
  logic [31:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "in_miss" means a refill is outstanding, "pend" means a
  // redirect is waiting for that refill to end.
  logic [31:0] m_pc, m_id_pc, m_id_insn, m_tgt, m_cnt;
  logic        m_id_en;
  bit          m_in_miss, m_pend;

  if_fetch_ctrl #(
    .RESET_VECTOR(RV),
    .NOP_INSN    (NOP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .br_tkn  (br_tkn),
    .br_addr (br_addr),
    .insn    (insn),
    .if_busy (if_busy),
    .data_rdy(data_rdy),
    .if_pc   (if_pc),
    .id_pc   (id_pc),
    .id_insn (id_insn),
    .id_en   (id_en)
`ifdef IF_PERF_CNT_EN
    ,
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_id_en   = 1'b0;
    m_id_insn = NOP;
  endtask

  task automatic model_update(input bit r, input bit s, input bit b, input logic [31:0] ba,
                              input logic [31:0] ins, input bit bz, input bit rd);
    if (r) begin
      m_pc      = RV;
      m_id_pc   = 32'h0;
      m_id_insn = NOP;
      m_id_en   = 1'b0;
      m_in_miss = 1'b0;
      m_pend    = 1'b0;
      m_tgt     = 32'h0;
      m_cnt     = 32'h0;
    end else begin
      if (m_in_miss && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (b) begin
        model_bubble();
        if (m_in_miss) begin
          m_pend = 1'b1;
          m_tgt  = ba & ~32'd3;
        end else begin
          m_pc = ba & ~32'd3;
        end
      end else if (!s) begin
        if (bz) begin
          m_in_miss = 1'b1;
          model_bubble();
        end else if (m_pend) begin
          m_pc      = m_tgt;
          m_pend    = 1'b0;
          m_in_miss = 1'b0;
          model_bubble();
        end else if (rd) begin
          m_id_pc   = m_pc;
          m_id_insn = ins;
          m_id_en   = 1'b1;
          m_pc      = m_pc + 32'd4;
          m_in_miss = 1'b0;
        end else begin
          model_bubble();
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare 1 ns after the edge.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] ba,
                      input logic [31:0] ins, input bit bz, input bit rd);
    rst      = r;
    stall    = s;
    br_tkn   = b;
    br_addr  = ba;
    insn     = ins;
    if_busy  = bz;
    data_rdy = rd;
    @(posedge clk);
    model_update(r, s, b, ba, ins, bz, rd);
    #1;
    check("if_pc", if_pc, m_pc);
    check("id_pc", id_pc, m_id_pc);
    check("id_insn", id_insn, m_id_insn);
    check("id_en", {31'b0, id_en}, {31'b0, m_id_en});
`ifdef IF_PERF_CNT_EN
    check("miss_cnt", miss_cnt, m_cnt);
`endif
  endtask

  task automatic fetch(input logic [31:0] ins);
    step(0, 0, 0, 32'h0, ins, 0, 1);
  endtask

  initial begin
    // Reset state.
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    check("rst_if_pc", if_pc, RV);
    check("rst_id_en", {31'b0, id_en}, 32'h0);
    check("rst_id_insn", id_insn, NOP);

    // Straight-line fetch.
    fetch(32'hA000_0001);
    check("seq_if_pc1", if_pc, 32'h4);
    check("seq_id_pc0", id_pc, 32'h0);
    check("seq_id_en0", {31'b0, id_en}, 32'h1);
    fetch(32'hA000_0002);
    fetch(32'hA000_0003);
    check("seq_if_pc3", if_pc, 32'hC);
    check("seq_id_pc2", id_pc, 32'h8);
    check("seq_id_insn2", id_insn, 32'hA000_0003);

    // Stall holds everything with id_pc at 0x10.
    fetch(32'hA000_0004);
    fetch(32'hA000_0005);
    check("stall_pre_id_pc", id_pc, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0, 32'hBAD0_0000, 0, 1);
      check("stall_id_pc", id_pc, 32'h10);
      check("stall_if_pc", if_pc, 32'h14);
    end
    fetch(32'hA000_0006);
    check("stall_post_id_pc", id_pc, 32'h14);

    // Redirect in FETCH drops the low address bits; concurrent stall ignored.
    step(0, 1, 1, 32'h203, 32'h0, 0, 1);
    check("br_if_pc", if_pc, 32'h200);
    check("br_id_en", {31'b0, id_en}, 32'h0);
    check("br_id_insn", id_insn, NOP);

    // PC wraps from the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFF, 32'h0, 0, 1);
    check("wrap_pre_pc", if_pc, 32'hFFFF_FFFC);
    fetch(32'hC0DE_0001);
    check("wrap_if_pc", if_pc, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

    // Five-cycle miss at 0x40.
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    step(0, 0, 1, 32'h40, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 32'h0, 32'hBAD0_0001, 1, 0);
      check("miss_if_pc", if_pc, 32'h40);
      check("miss_id_en", {31'b0, id_en}, 32'h0);
    end
    fetch(32'hC0DE_0040);
    check("miss_resume_id_pc", id_pc, 32'h40);
    check("miss_resume_if_pc", if_pc, 32'h44);
`ifdef IF_PERF_CNT_EN
    check("miss_cnt5", miss_cnt, 32'd5);
`endif

    // Redirect during a miss waits for the refill and discards its data.
    step(0, 0, 1, 32'h80, 32'h0, 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 1, 32'h300, 32'h0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 32'h0, 32'h0, 1, 0);
      check("pend_if_pc", if_pc, 32'h80);
    end
    step(0, 0, 0, 32'h0, 32'hBAD0_0080, 0, 1);
    check("pend_if_pc_tgt", if_pc, 32'h300);
    check("pend_id_en", {31'b0, id_en}, 32'h0);

    // Reset in the middle of a miss with a redirect pending.
    step(0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 0, 1, 32'h500, 32'h0, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0);
    check("rstmiss_if_pc", if_pc, RV);
`ifdef IF_PERF_CNT_EN
    check("rstmiss_cnt", miss_cnt, 32'd0);
`endif
    fetch(32'hC0DE_0000);
    check("rstmiss_id_pc", id_pc, RV);
    check("rstmiss_if_pc2", if_pc, RV + 32'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 15), ($urandom_range(99) < 8),
           $urandom, $urandom, ($urandom_range(99) < 25), ($urandom_range(99) < 80));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
